reg_file_param: RTL and testbench

REG_FILE_PARAM -- requirements
Module: reg_file_param

---
 rtl/reg_file_param.sv | 133 +++++++++++++
 tb/tb_reg_file_param.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// reg_file_param: parameterised register file with a per-register busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by macro REGFILE_BYPASS_EN.
module reg_file_param #(
  parameter int WORD_LEN = 32,
  parameter int ADDR_LEN = 4,
  parameter int RD_PORTS = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_LEN-1:0]          wr_addr,
  input  logic [WORD_LEN-1:0]          wr_data,
  input  logic                         rsv_en,
  input  logic [ADDR_LEN-1:0]          rsv_addr,
  input  logic                         flush,
  input  logic [RD_PORTS*ADDR_LEN-1:0] rd_addr,
  output logic [RD_PORTS*WORD_LEN-1:0] rd_data,
  output logic [RD_PORTS-1:0]          rd_busy,
  output logic [ADDR_LEN:0]            busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_LEN;

  logic [WORD_LEN-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]    r_busy;
  logic [ADDR_LEN:0]   r_busy_cnt;

  logic [DEPTH-1:0]    w_keep_mask;
  logic [DEPTH-1:0]    w_rsv_mask;
  logic [DEPTH-1:0]    w_clr_mask;
  logic [DEPTH-1:0]    w_busy_nxt;
  logic                w_wr_ok;

  function automatic logic [ADDR_LEN:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_LEN:0] cnt;
    cnt = {(ADDR_LEN+1){1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      cnt = cnt + {{ADDR_LEN{1'b0}}, v[k]};
    end
    return cnt;
  endfunction

  // Register 0 is excluded from storage, reservation and reads when hardwired to zero.
  always_comb begin
    w_keep_mask = {DEPTH{1'b1}};
    if (ZERO_REG) begin
      w_keep_mask[0] = 1'b0;
    end else begin
      w_keep_mask[0] = 1'b1;
    end
  end

  // Next busy vector: write-back retires, reservation sets and wins ties, flush clears all.
  always_comb begin
    w_rsv_mask = {DEPTH{1'b0}};
    w_clr_mask = {DEPTH{1'b0}};
    if (rsv_en) begin
      w_rsv_mask[rsv_addr] = 1'b1;
    end else begin
      w_rsv_mask = {DEPTH{1'b0}};
    end
    if (wr_en) begin
      w_clr_mask[wr_addr] = 1'b1;
    end else begin
      w_clr_mask = {DEPTH{1'b0}};
    end
    if (flush) begin
      w_busy_nxt = {DEPTH{1'b0}};
    end else begin
      w_busy_nxt = ((r_busy & ~w_clr_mask) | w_rsv_mask) & w_keep_mask;
    end
    w_wr_ok = wr_en & w_keep_mask[wr_addr];
  end

  // Storage array; the write of a flush cycle still lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= {WORD_LEN{1'b0}};
      end
    end else begin
      if (w_wr_ok) begin
        r_mem[wr_addr] <= wr_data;
      end
    end
  end

  // Scoreboard state and its registered population count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy     <= {DEPTH{1'b0}};
      r_busy_cnt <= {(ADDR_LEN+1){1'b0}};
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= popcount(w_busy_nxt);
    end
  end

  assign busy_cnt = r_busy_cnt;

  for (genvar g = 0; g < RD_PORTS; g++) begin : g_rd
    logic [ADDR_LEN-1:0] w_addr;
    logic [WORD_LEN-1:0] w_data;
    logic                w_busy;
    logic                w_byp;

    assign w_addr = rd_addr[g*ADDR_LEN +: ADDR_LEN];

    // Per-port read mux; a forwarded write is by definition no longer pending.
    always_comb begin
`ifdef REGFILE_BYPASS_EN
      w_byp = rst & wr_en & (wr_addr == w_addr) & w_keep_mask[w_addr];
`else
      w_byp = 1'b0;
`endif
      if (!w_keep_mask[w_addr]) begin
        w_data = {WORD_LEN{1'b0}};
        w_busy = 1'b0;
      end else if (w_byp) begin
        w_data = wr_data;
        w_busy = 1'b0;
      end else begin
        w_data = r_mem[w_addr];
        w_busy = r_busy[w_addr];
      end
    end

    assign rd_data[g*WORD_LEN +: WORD_LEN] = w_data;
    assign rd_busy[g]                      = w_busy;
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: array/flag model checked every cycle plus directed literals.
module tb_reg_file_param;
  localparam int AW = 4;
  localparam int WW = 32;
  localparam int NP = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WW-1:0]    wr_data;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic             flush;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*WW-1:0] rd_data;
  logic [NP-1:0]    rd_busy;
  logic [AW:0]      busy_cnt;

  reg_file_param #(.WORD_LEN(WW), .ADDR_LEN(AW), .RD_PORTS(NP), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .busy_cnt(busy_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [WW-1:0] m_mem [DEPTH];
  bit            m_busy [DEPTH];

  // Model: a register array and a set of pending registers.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        m_mem[k]  <= 32'h0;
        m_busy[k] <= 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != 4'd0) m_mem[wr_addr] <= wr_data;
      if (wr_en) m_busy[wr_addr] <= 1'b0;
      if (flush) begin
        for (int k = 0; k < DEPTH; k++) m_busy[k] <= 1'b0;
      end else if (rsv_en && rsv_addr != 4'd0) begin
        m_busy[rsv_addr] <= 1'b1;
      end
    end
  end

  function automatic int m_count();
    int n = 0;
    for (int k = 0; k < DEPTH; k++) if (m_busy[k]) n++;
    return n;
  endfunction

  function automatic logic [WW-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 4'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (rst && wr_en && wr_addr == a) return wr_data;
`endif
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a);
    if (a == 4'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (rst && wr_en && wr_addr == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  bit            cmp_on = 1'b0;
  bit            hand_on = 1'b0;
  string         hand_tag;
  logic [WW-1:0] hand_d0, hand_d1;
  logic [NP-1:0] hand_busy;
  logic [AW:0]   hand_cnt;

  // Compare process: model every cycle, hand-computed literals when requested.
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("model rd_data%0d", p), 64'(rd_data[p*WW +: WW]), 64'(exp_data(rd_addr[p*AW +: AW])));
        chk($sformatf("model rd_busy%0d", p), 64'(rd_busy[p]), 64'(exp_busy(rd_addr[p*AW +: AW])));
      end
      chk("model busy_cnt", 64'(busy_cnt), 64'(m_count()));
    end
    if (hand_on) begin
      chk({hand_tag, " rd_data0"}, 64'(rd_data[WW-1:0]), 64'(hand_d0));
      chk({hand_tag, " rd_data1"}, 64'(rd_data[2*WW-1:WW]), 64'(hand_d1));
      chk({hand_tag, " rd_busy"}, 64'(rd_busy), 64'(hand_busy));
      chk({hand_tag, " busy_cnt"}, 64'(busy_cnt), 64'(hand_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hand(input string tag, input logic [WW-1:0] d0, input logic [WW-1:0] d1,
                      input logic [NP-1:0] b, input logic [AW:0] c);
    hand_tag = tag; hand_d0 = d0; hand_d1 = d1; hand_busy = b; hand_cnt = c;
    hand_on = 1'b1;
    @(negedge clk);
    #1;
    hand_on = 1'b0;
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 32'h0;
    rsv_en = 1'b0; rsv_addr = 4'd0; flush = 1'b0; rd_addr = 8'h00;
    #2 rst = 1'b0;
    #1 cmp_on = 1'b1;

    // Inputs held active during reset are ignored.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
    rsv_en = 1'b1; rsv_addr = 4'd5; rd_addr = {4'd0, 4'd5};
    hand("in_reset", 32'h0, 32'h0, 2'b00, 5'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    idle();
    hand("after_release", 32'hDEADBEEF, 32'h0, 2'b01, 5'd1);

    // Asynchronous reset mid-cycle clears r5 and the count before any edge.
    @(posedge clk); #2;
    rst = 1'b0;
    hand("async_reset", 32'h0, 32'h0, 2'b00, 5'd0);
    rst = 1'b1;

    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h12345678; rd_addr = {4'd3, 4'd3};
    tick(); idle();
    hand("wr_r3", 32'h12345678, 32'h12345678, 2'b00, 5'd0);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFFFFFF; rd_addr = {4'd0, 4'd0};
    tick(); idle();
    hand("wr_r0", 32'h0, 32'h0, 2'b00, 5'd0);

    rsv_en = 1'b1; rsv_addr = 4'd7; tick();
    rsv_addr = 4'd9; tick(); idle();
    rd_addr = {4'd9, 4'd7};
    hand("rsv_7_9", 32'h0, 32'h0, 2'b11, 5'd2);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h00000077; tick(); idle();
    hand("wr_r7", 32'h00000077, 32'h0, 2'b10, 5'd1);
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h00000099;
    rsv_en = 1'b1; rsv_addr = 4'd9; tick(); idle();
    hand("rsv_wr_r9", 32'h00000077, 32'h00000099, 2'b10, 5'd1);

    rsv_en = 1'b1; rsv_addr = 4'd1; tick();
    rsv_addr = 4'd2; tick();
    rsv_addr = 4'd3; tick(); idle();
    rd_addr = {4'd3, 4'd1};
    hand("pre_flush", 32'h0, 32'h12345678, 2'b11, 5'd4);
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 4'd4;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h00000022; tick(); idle();
    rd_addr = {4'd2, 4'd4};
    hand("flush", 32'h0, 32'h00000022, 2'b00, 5'd0);

    rsv_en = 1'b1; rsv_addr = 4'd6; tick(); idle();
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 32'hA5A5A5A5; rd_addr = {4'd9, 4'd6};
`ifdef REGFILE_BYPASS_EN
    hand("bypass", 32'hA5A5A5A5, 32'h00000099, 2'b00, 5'd1);
`else
    hand("no_bypass", 32'h0, 32'h00000099, 2'b01, 5'd1);
`endif
    tick(); idle();
    hand("after_wr_r6", 32'hA5A5A5A5, 32'h00000099, 2'b00, 5'd0);

    for (int i = 0; i < 300; i++) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = 4'($urandom_range(0, 15));
      wr_data  = $urandom;
      rsv_en   = 1'($urandom_range(0, 1));
      rsv_addr = 4'($urandom_range(0, 15));
      flush    = ($urandom_range(0, 15) == 0);
      rd_addr  = 8'($urandom);
      tick();
    end
    idle();
    @(negedge clk); #1;
    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
